// File: rtl/wgt_load_ctrl.sv
// -----------------------------------------------------------------------------
// wgt_load_ctrl
// Loads one 3x3 signed 8-bit kernel from the weight SRAM into the three
// row-wise weight shift buffers of the PE array, then holds it until the
// compute engine releases it.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         single-cycle load request, samples kernel_idx
//   kernel_idx    kernel number to load
//   compute_done  single-cycle release of the held kernel
//   mem_en        SRAM read enable
//   mem_addr      SRAM read address
//   mem_rdata     SRAM read data (valid the cycle after mem_en)
//   wgt_data      byte broadcast to all row buffers (copy of mem_rdata)
//   wgt_rd        one-hot row shift strobe, bit r shifts row buffer r
//   busy          high while fetching, draining or holding a kernel
//   wgt_valid     kernel fully loaded and held
//   load_done     single-cycle pulse on entry to READY
//   idx_err       single-cycle pulse for an out-of-range kernel_idx
// -----------------------------------------------------------------------------
module wgt_load_ctrl #(
   parameter int NUM_KERNELS = 64,
   parameter int ADDR_W      = 10,
   parameter int KIDX_W      = 6,
   parameter int BASE_ADDR   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [KIDX_W-1:0] kernel_idx,
   input  logic              compute_done,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        wgt_data,
   output logic [2:0]        wgt_rd,
   output logic              busy,
   output logic              wgt_valid,
   output logic              load_done,
   output logic              idx_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_READY = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] BASE_L = ADDR_W'(BASE_ADDR);
   localparam logic [31:0]       NK_L   = 32'(NUM_KERNELS);

   // Row of issue n (0..8) by range compare instead of dividing by three.
   function automatic logic [2:0] row_onehot(input logic [3:0] n);
      logic [2:0] oh;
      if (n >= 4'd6) begin
         oh = 3'b100;
      end else if (n >= 4'd3) begin
         oh = 3'b010;
      end else begin
         oh = 3'b001;
      end
      return oh;
   endfunction

   state_t            state_r, state_nx_s;
   logic [3:0]        n_r, n_nx_s;
   logic [ADDR_W-1:0] mem_addr_r, addr_nx_s;
   logic              mem_en_r;
   logic [2:0]        wgt_rd_r;
   logic              busy_r, wgt_valid_r, load_done_r, idx_err_r;
   logic              err_nx_s;
   logic              idx_legal_s;
   logic [ADDR_W-1:0] idx_ext_s, base_calc_s;

   // Kernel base address: BASE_ADDR + 9*idx computed as (idx<<3)+idx.
   always_comb begin
      idx_legal_s = (32'(kernel_idx) < NK_L);
      idx_ext_s   = ADDR_W'(kernel_idx);
      base_calc_s = BASE_L + (idx_ext_s << 3'd3) + idx_ext_s;
   end

   // Next-state, issue counter and next issue address.
   always_comb begin
      state_nx_s = state_r;
      n_nx_s     = n_r;
      addr_nx_s  = '0;
      err_nx_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (idx_legal_s) begin
                  state_nx_s = ST_FETCH;
                  n_nx_s     = 4'd0;
                  addr_nx_s  = base_calc_s;
               end else begin
                  err_nx_s   = 1'b1;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (n_r == 4'd8) begin
               state_nx_s = ST_DRAIN;
               n_nx_s     = 4'd0;
            end else begin
               n_nx_s     = n_r + 4'd1;
               addr_nx_s  = mem_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
         end
         ST_DRAIN: begin
            state_nx_s = ST_READY;
         end
         ST_READY: begin
            if (compute_done) begin
               if (start && idx_legal_s) begin
                  // back-to-back reload of the next kernel
                  state_nx_s = ST_FETCH;
                  n_nx_s     = 4'd0;
                  addr_nx_s  = base_calc_s;
               end else if (start) begin
                  state_nx_s = ST_IDLE;
                  err_nx_s   = 1'b1;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end else begin
               state_nx_s = ST_READY;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            n_nx_s     = 4'd0;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         n_r         <= 4'd0;
         mem_en_r    <= 1'b0;
         mem_addr_r  <= '0;
         wgt_rd_r    <= 3'b000;
         busy_r      <= 1'b0;
         wgt_valid_r <= 1'b0;
         load_done_r <= 1'b0;
         idx_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         n_r         <= n_nx_s;
         mem_en_r    <= (state_nx_s == ST_FETCH);
         mem_addr_r  <= addr_nx_s;
         // row tag of the read issued this cycle, aligned with next mem_rdata
         wgt_rd_r    <= (state_r == ST_FETCH) ? row_onehot(n_r) : 3'b000;
         busy_r      <= (state_nx_s != ST_IDLE);
         wgt_valid_r <= (state_nx_s == ST_READY);
         load_done_r <= (state_nx_s == ST_READY) && (state_r != ST_READY);
         idx_err_r   <= err_nx_s;
      end
   end

   assign mem_en    = mem_en_r;
   assign mem_addr  = mem_addr_r;
   assign wgt_data  = mem_rdata;
   assign wgt_rd    = wgt_rd_r;
   assign busy      = busy_r;
   assign wgt_valid = wgt_valid_r;
   assign load_done = load_done_r;
   assign idx_err   = idx_err_r;

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wgt_load_ctrl
// Self-checking bench: SRAM and row-buffer models around the DUT, and a
// reference model that tracks "cycles since accepted start" and derives every
// expected output from that distance.
// -----------------------------------------------------------------------------
module tb_wgt_load_ctrl;
   localparam int NK = 64;
   localparam int AW = 10;
   localparam int KW = 7;
   localparam int BA = 0;

   logic          clk = 1'b0;
   logic          rst_n, start, compute_done;
   logic [KW-1:0] kernel_idx;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata, wgt_data;
   logic [2:0]    wgt_rd;
   logic          busy, wgt_valid, load_done, idx_err;

   always #5 clk = ~clk;

   wgt_load_ctrl #(.NUM_KERNELS(NK), .ADDR_W(AW), .KIDX_W(KW), .BASE_ADDR(BA)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .kernel_idx(kernel_idx),
      .compute_done(compute_done), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .wgt_data(wgt_data), .wgt_rd(wgt_rd),
      .busy(busy), .wgt_valid(wgt_valid), .load_done(load_done), .idx_err(idx_err)
   );

   logic [7:0] sram [0:1023];
   logic [7:0] row_buf [0:2][0:2];

   // SRAM with one-cycle read latency
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= sram[mem_addr];
   end

   // Row shift buffers: new byte enters tap 0
   always @(posedge clk) begin
      for (int r = 0; r < 3; r++) begin
         if (wgt_rd[r]) begin
            row_buf[r][2] <= row_buf[r][1];
            row_buf[r][1] <= row_buf[r][0];
            row_buf[r][0] <= wgt_data;
         end
      end
   end

   int total = 0;
   int bad   = 0;
   int d     = -1;   // cycles since accepted start, -1 when idle
   int base  = 0;
   bit err_pend = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h d=%0d t=%0t", tag, got, exp, d, $time);
      end
   endtask

   // One clock: check outputs at the falling edge, then advance the model.
   task automatic step();
      logic       en_e;
      logic [2:0] rd_e;
      int         dn;
      bit         errn;
      @(negedge clk);
      if (!rst_n) begin
         d        = -1;
         err_pend = 1'b0;
      end
      en_e = (d >= 1 && d <= 9);
      rd_e = (d >= 2 && d <= 10) ? 3'(1 << ((d - 2) / 3)) : 3'b000;
      check_val("mem_en", 32'(mem_en), 32'(en_e));
      if (en_e) check_val("mem_addr", 32'(mem_addr), 32'(base + d - 1));
      check_val("wgt_rd", 32'(wgt_rd), 32'(rd_e));
      if (rd_e != 3'b000) check_val("wgt_data", 32'(wgt_data), 32'(sram[base + d - 2]));
      check_val("busy", 32'(busy), 32'(d >= 1));
      check_val("wgt_valid", 32'(wgt_valid), 32'(d >= 11));
      check_val("load_done", 32'(load_done), 32'(d == 11));
      check_val("idx_err", 32'(idx_err), 32'(err_pend));
      if (d == 11) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               check_val($sformatf("row%0d_c%0d", r, c), 32'(row_buf[r][2 - c]),
                         32'(sram[base + 3 * r + c]));
            end
         end
      end
      errn = 1'b0;
      if (!rst_n) begin
         dn = -1;
      end else if (d == -1 || (d >= 11 && compute_done)) begin
         if (start) begin
            if (int'(kernel_idx) < NK) begin
               dn   = 1;
               base = BA + 9 * int'(kernel_idx);
            end else begin
               dn   = -1;
               errn = 1'b1;
            end
         end else begin
            dn = -1;
         end
      end else if (d >= 11) begin
         dn = 12;
      end else begin
         dn = d + 1;
      end
      d        = dn;
      err_pend = errn;
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_start(input int k);
      start      = 1'b1;
      kernel_idx = KW'(k);
      step();
      start      = 1'b0;
   endtask

   task automatic release_kernel();
      compute_done = 1'b1;
      step();
      compute_done = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; compute_done = 1'b0; kernel_idx = '0;
      for (int a = 0; a < 1024; a++) sram[a] = 8'(a + 1);
      steps(3);
      rst_n = 1'b1;
      steps(2);

      // kernel 0 with a spurious start during FETCH
      do_start(0);
      steps(3);
      start = 1'b1; kernel_idx = 7'd5; step(); start = 1'b0;
      steps(10);
      release_kernel();
      steps(2);
      // compute_done in IDLE is ignored
      release_kernel();
      steps(2);

      // last kernel with extreme signed bytes
      sram[570] = 8'h80;
      sram[575] = 8'h7F;
      do_start(63);
      steps(14);
      release_kernel();
      steps(1);

      // illegal indices
      do_start(64);
      steps(3);
      do_start(127);
      steps(2);

      // back-to-back reload of kernel 5
      do_start(7);
      steps(12);
      compute_done = 1'b1; start = 1'b1; kernel_idx = 7'd5;
      step();
      compute_done = 1'b0; start = 1'b0;
      steps(13);
      // release together with an illegal start
      compute_done = 1'b1; start = 1'b1; kernel_idx = 7'd100;
      step();
      compute_done = 1'b0; start = 1'b0;
      steps(3);

      // reset mid-load at S+6
      do_start(10);
      steps(5);
      rst_n = 1'b0;
      steps(2);
      rst_n = 1'b1;
      steps(5);
      do_start(10);
      steps(13);
      release_kernel();

      // randomized traffic
      for (int a = 0; a < 1024; a++) sram[a] = 8'($urandom);
      for (int i = 0; i < 600; i++) begin
         start        = ($urandom_range(0, 5) == 0);
         kernel_idx   = KW'($urandom_range(0, 75));
         compute_done = ($urandom_range(0, 4) == 0);
         step();
      end
      start = 1'b0; compute_done = 1'b0;
      steps(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wgt_load_ctrl.md
# wgt_load_ctrl

Sequencer that loads one 3x3 signed 8-bit kernel from the on-chip weight SRAM into the three row-wise weight shift buffers of the 3x3 PE array. It issues nine SRAM reads per kernel and steers each returned byte to the correct row buffer with a one-hot shift strobe. It then holds the kernel stable for the compute engine until the engine releases it. It sits between the layer scheduler (start/kernel index) and the weight SRAM plus the three row shift buffers.

## Interface
- NUM_KERNELS, 64, number of kernels stored in weight SRAM
- ADDR_W, 10, weight SRAM address width; must satisfy 9*NUM_KERNELS + BASE_ADDR <= 2^ADDR_W
- KIDX_W, 6, kernel index width
- BASE_ADDR, 0, SRAM address of weight w[k=0][r=0][c=0]

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to load kernel kernel_idx
- kernel_idx  in  KIDX_W  kernel number, sampled with start
- compute_done  in  1  single-cycle pulse from compute engine releasing the held kernel
- mem_en  out  1  SRAM read enable
- mem_addr  out  ADDR_W  SRAM read address
- mem_rdata  in  8  signed SRAM read data, valid the cycle after mem_en
- wgt_data  out  8  signed byte to all row buffers (combinational copy of mem_rdata)
- wgt_rd  out  3  one-hot shift strobe; bit r shifts row buffer r
- busy  out  1  high in FETCH, DRAIN and READY
- wgt_valid  out  1  kernel fully loaded and held
- load_done  out  1  single-cycle pulse on entry to READY
- idx_err  out  1  single-cycle pulse when start carries kernel_idx >= NUM_KERNELS

## Operation
- Memory layout is row-major: w[k][r][c] is at BASE_ADDR + 9k + 3r + c.
- FSM states: IDLE, FETCH, DRAIN, READY.
- IDLE: start with a legal index latches base = BASE_ADDR + 9*kernel_idx, clears the issue counter n (0..8) and moves to FETCH.
  - start with an illegal index pulses idx_err, then stays in IDLE with nothing issued.
- FETCH: each cycle drives mem_en=1 and mem_addr=base+n, then increments n.
  - Leaves for DRAIN after issuing n=8.
  - The row of issue n is n/3, derived from the n counter; no divider.
- Issue pipeline: a registered row tag follows each mem_en. In the next cycle wgt_rd equals one-hot(row of that issue), aligned with mem_rdata.
- DRAIN: one cycle. The last byte (n=8) is strobed into row 2. Then the FSM enters READY and load_done pulses.
- Resulting buffer contents: within each row, c=0 ends in tap 2, c=1 in tap 1, c=2 in tap 0.
- READY: wgt_valid=1. mem_en=0 and wgt_rd=0, so the buffers are frozen.
  - compute_done returns the FSM to IDLE.
  - compute_done together with a legal start goes straight to FETCH for the new kernel (back-to-back reload).
  - compute_done together with an illegal start pulses idx_err and goes to IDLE.
- start outside IDLE/READY is ignored, as is start in READY without compute_done. compute_done outside READY is ignored.
- Address arithmetic uses ADDR_W-bit unsigned values; 9*kernel_idx is computed as (idx<<3)+idx, zero-extended.

## Timing
- Reset value of every output is 0: mem_en, mem_addr, wgt_rd, busy, wgt_valid, load_done, idx_err. wgt_data follows mem_rdata.
- Taking cycle S as the cycle start is sampled high in IDLE:
  - mem_en is high in S+1..S+9, with addresses base..base+8.
  - wgt_rd is 001 in S+2..S+4, 010 in S+5..S+7 and 100 in S+8..S+10.
  - wgt_valid rises at S+11, and load_done is high in S+11 only.
- Load latency is 11 cycles from start to wgt_valid.
- busy rises at S+1 and falls the cycle after compute_done is accepted.
- wgt_valid falls the cycle after compute_done.
  - On a back-to-back reload, wgt_valid is low from that cycle until the new load completes, 10 cycles later.
- Reset asserted mid-load immediately clears the FSM, counters, row tag and all strobes. No partial strobe occurs after reset, and the row buffers keep whatever they had shifted in so far. The first load after reset needs a fresh start.

## Test plan
- Kernel 0: SRAM filled with byte (addr+1); start with idx 0 -> mem_addr 0..8 in S+1..S+9; row0 taps {2,1,0} = {1,2,3}, row1 = {4,5,6}, row2 = {7,8,9}; wgt_valid at S+11.
- Last kernel: idx 63, BASE_ADDR 0 -> addresses 567..575; signed bytes 0x80 and 0x7F are delivered unchanged.
- Illegal index: start with idx 64 -> idx_err pulses for 1 cycle, mem_en never rises, busy stays 0.
- Back-to-back: in READY, compute_done and start idx 5 in the same cycle -> mem_en the next cycle at address 45, wgt_valid low for 10 cycles, then high.
- Ignored inputs: start during FETCH, and compute_done in IDLE -> no change to the address sequence or state.
- Reset mid-load: assert rst_n low at S+6 -> all outputs 0 the same cycle; after release, no strobe until a new start, which then completes a full 11-cycle load.
